// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between WB and a buffered multi-cycle unit
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_valid,
  input  logic [4:0]        mc_reg,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  output logic              rf_RegWrite,
  output logic [4:0]        rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [31:0]       pending_mask,
  output logic              pipe_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Buffered secondary writes; live_q marks entries that still need to reach the register file
  logic [4:0]        ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DEPTH-1:0]  live_q, live_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;

  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_reg_q, rf_reg_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic fifo_empty;
  logic head_live;
  logic wb_req;
  logic wb_wins;
  logic push;
  logic pop;
  logic starve_inc;

  assign fifo_empty = (count_q == '0);
  assign head_live  = !fifo_empty && live_q[rd_ptr_q];
  // A write to r0 is a no-op, so WB treats it as an idle slot the FIFO may use
  assign wb_req     = wb_valid && (wb_reg != 5'd0);
  assign wb_wins    = !stall_q && wb_req;
  // Readiness looks only at the occupancy before the edge: a full FIFO refuses even if it drains now
  assign mc_ready   = rst_n && (count_q < CW'(DEPTH));
  // r0 writes are handshaken but never stored
  assign push       = mc_valid && mc_ready && (mc_reg != 5'd0);
  // The head leaves whenever the slot is not taken by WB (including forced stall cycles)
  assign pop        = !fifo_empty && !wb_wins;
  assign starve_inc = wb_wins && head_live;

  // Select what drives the write port next cycle; address/data hold when nothing is written
  always_comb begin
    rf_we_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    if (wb_wins) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = wb_reg;
      rf_data_d = wb_data;
    end else if (pop && head_live) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = ent_reg_q[rd_ptr_q];
      rf_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // FIFO bookkeeping: squash older entries hit by a WB write, retire the head, then mark the new entry
  always_comb begin
    live_d = live_q;
    if (wb_wins) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_reg_q[i] == wb_reg) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Count WB wins over a live head; on the limit, steal exactly one cycle for the FIFO
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (starve_inc) begin
      if (starve_q >= SW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else                                     starve_d = starve_q + SW'(1);
    end
  end

  // Registers that feed the hazard unit: one bit per register with a live buffered write
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask[ent_reg_q[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // Control state and write-port registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      live_q    <= live_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
      rf_we_q   <= rf_we_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Entry payload storage; contents are meaningless unless the matching live bit is set
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[wr_ptr_q]  <= mc_reg;
      ent_data_q[wr_ptr_q] <= mc_data;
    end
  end

  assign rf_RegWrite   = rf_we_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;
  assign pipe_stall    = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_reg;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_RegWrite;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;
  logic        pipe_stall;

  int n_cmp = 0;
  int n_err = 0;

  regfile_write_arbiter #(.DEPTH(4), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .mc_valid     (mc_valid),
    .mc_reg       (mc_reg),
    .mc_data      (mc_data),
    .mc_ready     (mc_ready),
    .rf_RegWrite  (rf_RegWrite),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .pending_mask (pending_mask),
    .pipe_stall   (pipe_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".we"},   {31'd0, rf_RegWrite}, {31'd0, we});
    chk({tag, ".reg"},  {27'd0, rf_write_reg}, {27'd0, r});
    chk({tag, ".data"}, rf_write_data, d);
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    mc_valid = 1'b0; mc_reg = '0; mc_data = '0;

    // reset state
    tick(); tick();
    chk_rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst.stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst.mask", pending_mask, 32'h0);
    chk("rst.ready", {31'd0, mc_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle.ready", {31'd0, mc_ready}, 32'd1);

    // WB only, then WB to r0 (no write, address/data held)
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'habcdef12;
    tick();
    chk_rf("wb3", 1'b1, 5'd3, 32'habcdef12);
    chk("wb3.mask", pending_mask, 32'h0);
    wb_reg = 5'd0; wb_data = 32'h55555555;
    tick();
    chk_rf("wb0", 1'b0, 5'd3, 32'habcdef12);

    // two buffered writes held behind WB, then drained in order
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h100;
    mc_valid = 1'b1; mc_reg = 5'd5; mc_data = 32'h11;
    tick();
    chk_rf("mc.a", 1'b1, 5'd1, 32'h100);
    chk("mc.a.mask", pending_mask, 32'h20);
    wb_data = 32'h101; mc_reg = 5'd6; mc_data = 32'h22;
    tick();
    chk_rf("mc.b", 1'b1, 5'd1, 32'h101);
    chk("mc.b.mask", pending_mask, 32'h60);
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    chk_rf("drain5", 1'b1, 5'd5, 32'h11);
    chk("drain5.mask", pending_mask, 32'h40);
    tick();
    chk_rf("drain6", 1'b1, 5'd6, 32'h22);
    chk("drain6.mask", pending_mask, 32'h0);
    tick();
    chk_rf("drained", 1'b0, 5'd6, 32'h22);

    // fill to full while WB is busy, hold a fifth offer, no entry lost
    wb_valid = 1'b1; wb_reg = 5'd1;
    for (int k = 0; k < 4; k++) begin
      wb_data = 32'h200 + k;
      mc_valid = 1'b1; mc_reg = 5'(8 + k); mc_data = 32'h80 + k;
      tick();
      chk_rf("fill", 1'b1, 5'd1, 32'h200 + k);
      chk("fill.ready", {31'd0, mc_ready}, (k < 3) ? 32'd1 : 32'd0);
    end
    chk("full.mask", pending_mask, 32'h0000_0f00);
    mc_reg = 5'd12; mc_data = 32'h84; wb_data = 32'h204;
    tick();
    chk_rf("full.wb", 1'b1, 5'd1, 32'h204);
    chk("full.ready", {31'd0, mc_ready}, 32'd0);
    chk("full.mask2", pending_mask, 32'h0000_0f00);
    wb_valid = 1'b0;
    tick();
    chk_rf("full.pop8", 1'b1, 5'd8, 32'h80);
    chk("full.ready2", {31'd0, mc_ready}, 32'd1);
    chk("full.mask3", pending_mask, 32'h0000_0e00);
    tick();
    chk_rf("full.pop9", 1'b1, 5'd9, 32'h81);
    chk("full.mask4", pending_mask, 32'h0000_1c00);
    mc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_rf("full.drain", 1'b1, 5'(10 + k), 32'h82 + k);
    end
    chk("full.mask5", pending_mask, 32'h0);
    tick();
    chk("full.idle", {31'd0, rf_RegWrite}, 32'd0);

    // squash: an older buffered r7 is killed by a newer WB write to r7
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'hAA;
    tick();
    chk("sq.mask1", pending_mask, 32'h80);
    chk("sq.we1", {31'd0, rf_RegWrite}, 32'd0);
    mc_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hBB;
    tick();
    chk_rf("sq.wb", 1'b1, 5'd7, 32'hBB);
    chk("sq.mask2", pending_mask, 32'h0);
    wb_valid = 1'b0;
    tick();
    chk_rf("sq.dead", 1'b0, 5'd7, 32'hBB);
    tick();
    chk_rf("sq.after", 1'b0, 5'd7, 32'hBB);

    // an entry pushed at the same edge as the WB write is newer and survives
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hDD;
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'hEE;
    tick();
    chk_rf("same.wb", 1'b1, 5'd7, 32'hDD);
    chk("same.mask", pending_mask, 32'h80);
    wb_valid = 1'b0; mc_valid = 1'b0;
    tick();
    chk_rf("same.drain", 1'b1, 5'd7, 32'hEE);
    chk("same.mask2", pending_mask, 32'h0);

    // mc write to r0 is accepted but never stored or drained
    mc_valid = 1'b1; mc_reg = 5'd0; mc_data = 32'h99;
    tick();
    chk("r0.mask", pending_mask, 32'h0);
    chk("r0.ready", {31'd0, mc_ready}, 32'd1);
    mc_valid = 1'b0;
    tick();
    chk("r0.we", {31'd0, rf_RegWrite}, 32'd0);

    // starvation: 8 WB wins over a live head force one stall cycle
    mc_valid = 1'b1; mc_reg = 5'd20; mc_data = 32'h2020;
    tick();
    chk("st.mask", pending_mask, 32'h0010_0000);
    mc_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd2;
    for (int k = 1; k <= 8; k++) begin
      wb_data = 32'(k);
      tick();
      chk("st.stall", {31'd0, pipe_stall}, (k == 8) ? 32'd1 : 32'd0);
      chk("st.data", rf_write_data, 32'(k));
    end
    wb_data = 32'd9;
    tick();
    chk_rf("st.drain", 1'b1, 5'd20, 32'h2020);
    chk("st.stall2", {31'd0, pipe_stall}, 32'd0);
    chk("st.mask2", pending_mask, 32'h0);
    tick();
    chk_rf("st.replay", 1'b1, 5'd2, 32'd9);

    // counter restarts from zero: another full run is needed for the next stall
    mc_valid = 1'b1; mc_reg = 5'd21; mc_data = 32'h2121; wb_data = 32'd10;
    tick();
    chk_rf("st2.push", 1'b1, 5'd2, 32'd10);
    mc_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wb_data = 32'(10 + k);
      tick();
      chk("st2.stall", {31'd0, pipe_stall}, (k == 8) ? 32'd1 : 32'd0);
    end
    wb_valid = 1'b0;
    tick();
    chk_rf("st2.drain", 1'b1, 5'd21, 32'h2121);
    chk("st2.stall2", {31'd0, pipe_stall}, 32'd0);

    // reset mid-traffic discards buffered writes
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 32'h99;
    tick();
    chk("mid.mask", pending_mask, 32'h200);
    rst_n = 1'b0;
    tick();
    chk_rf("mid.rst", 1'b0, 5'd0, 32'h0);
    chk("mid.stall", {31'd0, pipe_stall}, 32'd0);
    chk("mid.mask2", pending_mask, 32'h0);
    chk("mid.ready", {31'd0, mc_ready}, 32'd0);
    rst_n = 1'b1; wb_valid = 1'b0; mc_valid = 1'b0;
    #1;
    chk("mid.ready2", {31'd0, mc_ready}, 32'd1);
    tick();
    chk("mid.we", {31'd0, rf_RegWrite}, 32'd0);
    chk("mid.mask3", pending_mask, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
